// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//   Sequencing controller for the iterative signed divider datapath.
//   Accepts a one-cycle divide request, latches both operands and holds them on
//   the datapath for the whole iteration. It clears, then enables, the divider
//   and waits for its ready flag. Divide-by-zero and the MIN/-1 overflow case
//   are screened without running the datapath. A watchdog aborts a run that
//   never completes.
//
// Ports
//   clk          in   system clock, all state on rising edge
//   clrn         in   asynchronous active-low reset
//   start        in   divide request, sampled only in IDLE
//   dividend     in   signed dividend, sampled with start
//   divisor      in   signed divisor, sampled with start
//   busy         out  high whenever the controller is not IDLE (pipeline stall)
//   done         out  one-cycle completion pulse
//   result       out  signed quotient (registered, held until next completion)
//   exception    out  divide-by-zero, overflow or watchdog abort (registered)
//   div_dividend out  latched dividend to the datapath
//   div_divisor  out  latched divisor to the datapath
//   div_clrn     out  active-low clear to the datapath registers/counter
//   div_ena      out  datapath register enable
//   div_out      in   datapath quotient
//   div_ready    in   datapath completion flag
//   dbg_state    out  current FSM state (debug observation only)
//
// Handshake: a request is taken when start=1 while busy=0 (IDLE); start while
// busy=1 is dropped, never queued. Completion is signalled by done=1 for
// exactly one cycle; result/exception are valid in that cycle and stay stable
// until the next accepted request. There is no backpressure on done.
// -----------------------------------------------------------------------------
module div_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_clrn,
  output logic             div_ena,
  input  logic [WIDTH-1:0] div_out,
  input  logic             div_ready,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] L_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] L_NEG_ONE = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] L_WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic [CNT_W-1:0] r_wdog;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_timeout;
  logic             w_busy;
  logic             w_done;
  logic             w_div_clrn;
  logic             w_div_ena;

  // Screens look at the live input buses because they act on the start edge.
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_div_zero = (divisor == '0);
  assign w_overflow = (dividend == L_MIN_NEG) && (divisor == L_NEG_ONE);
  assign w_timeout  = (r_wdog == L_WD_LAST);

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_div_clrn   = 1'b1;
    w_div_ena    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          if (w_div_zero || w_overflow) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        w_div_clrn   = 1'b0;
        w_next_state = S_RUN;
      end
      S_RUN: begin
        w_div_ena = 1'b1;
        if (div_ready || w_timeout) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand latches, result/exception registers and watchdog
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_wdog      <= '0;
    end else begin
      if (w_accept) begin
        r_dividend  <= dividend;
        r_divisor   <= divisor;
        r_exception <= 1'b0;
        // Zero divisor takes precedence over the overflow screen.
        if (w_div_zero) begin
          r_result    <= '0;
          r_exception <= 1'b1;
        end else if (w_overflow) begin
          r_result    <= L_MIN_NEG;
          r_exception <= 1'b1;
        end
      end

      if (r_state == S_CLEAR) begin
        r_wdog <= '0;
      end

      if (r_state == S_RUN) begin
        r_wdog <= r_wdog + 1'b1;
        // A ready flag on the final watchdog cycle still counts as success.
        if (div_ready) begin
          r_result    <= div_out;
          r_exception <= 1'b0;
        end else if (w_timeout) begin
          r_result    <= '0;
          r_exception <= 1'b1;
        end
      end
    end
  end

  assign busy         = w_busy;
  assign done         = w_done;
  assign result       = r_result;
  assign exception    = r_exception;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  // Reset also clears the datapath, independent of the registered state.
  assign div_clrn     = clrn & w_div_clrn;
  assign div_ena      = w_div_ena;
  assign dbg_state    = r_state;

endmodule
